// File: rtl/sevenseg_pkg.sv
// Shared definitions for the scrolling 7-segment display.
// Segment bytes are active-low {a,b,c,d,e,f,g,dp}.
// Contents:
//   SEG_BLANK / SEG_DP_ONLY / ASCII_SPACE  constants
//   slot_cycles()   clock cycles per digit slot
//   glyph()         active-high abcdefg pattern -> active-low segment byte (dp off)
//   hex_to_seg()    nibble -> segment byte
//   ascii_to_seg()  ASCII code -> segment byte (letters case-folded)
package sevenseg_pkg;

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [7:0] SEG_DP_ONLY = 8'hFE;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   function automatic int slot_cycles(input int clk_hz, input int refresh_hz, input int digits);
      return clk_hz / (refresh_hz * digits);
   endfunction

   function automatic logic [7:0] glyph(input logic [6:0] abcdefg);
      return ~{abcdefg, 1'b0};
   endfunction

   function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'b1111110;
         4'h1: p = 7'b0110000;
         4'h2: p = 7'b1101101;
         4'h3: p = 7'b1111001;
         4'h4: p = 7'b0110011;
         4'h5: p = 7'b1011011;
         4'h6: p = 7'b1011111;
         4'h7: p = 7'b1110000;
         4'h8: p = 7'b1111111;
         4'h9: p = 7'b1111011;
         4'hA: p = 7'b1110111;
         4'hB: p = 7'b0011111;
         4'hC: p = 7'b1001110;
         4'hD: p = 7'b0111101;
         4'hE: p = 7'b1001111;
         default: p = 7'b1000111;
      endcase
      return glyph(p);
   endfunction

   function automatic logic [7:0] ascii_to_seg(input logic [7:0] c);
      logic [7:0] u;
      logic [7:0] s;
      // fold lowercase onto uppercase so both share one glyph table
      u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
      s = SEG_DP_ONLY;
      if (u >= 8'h30 && u <= 8'h39) s = hex_to_seg(u[3:0]);
      else begin
         case (u)
            8'h20: s = SEG_BLANK;
            8'h2D: s = glyph(7'b0000001);
            8'h5F: s = glyph(7'b0001000);
            8'h41: s = hex_to_seg(4'hA);
            8'h42: s = hex_to_seg(4'hB);
            8'h43: s = hex_to_seg(4'hC);
            8'h44: s = hex_to_seg(4'hD);
            8'h45: s = hex_to_seg(4'hE);
            8'h46: s = hex_to_seg(4'hF);
            8'h47: s = glyph(7'b1011110);
            8'h48: s = glyph(7'b0110111);
            8'h49: s = glyph(7'b0000110);
            8'h4A: s = glyph(7'b0111100);
            8'h4B: s = glyph(7'b1010111);
            8'h4C: s = glyph(7'b0001110);
            8'h4D: s = glyph(7'b1010100);
            8'h4E: s = glyph(7'b0010101);
            8'h4F: s = glyph(7'b0011101);
            8'h50: s = glyph(7'b1100111);
            8'h51: s = glyph(7'b1110011);
            8'h52: s = glyph(7'b0000101);
            8'h53: s = glyph(7'b1011011);
            8'h54: s = glyph(7'b0001111);
            8'h55: s = glyph(7'b0111110);
            8'h56: s = glyph(7'b0011100);
            8'h57: s = glyph(7'b0101010);
            8'h58: s = glyph(7'b0110111);
            8'h59: s = glyph(7'b0111011);
            8'h5A: s = glyph(7'b1101101);
            default: s = SEG_DP_ONLY;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Keyboard/control bundle between the PS2 decoder side and the display.
//   key_strobe  new-data level (asynchronous to clk)
//   key_code    ASCII code
//   clear, view_up, view_down  single-cycle pulses
//   hex_mode    show newest code as two hex digits
//   brightness  duty level, only present when SEG_DIM_EN is defined
// Modports: master drives, slave (the display) receives.
interface sevenseg_if;
   logic       key_strobe;
   logic [7:0] key_code;
   logic       clear;
   logic       view_up;
   logic       view_down;
   logic       hex_mode;
`ifdef SEG_DIM_EN
   logic [3:0] brightness;
   modport master (output key_strobe, key_code, clear, view_up, view_down, hex_mode, brightness);
   modport slave  (input  key_strobe, key_code, clear, view_up, view_down, hex_mode, brightness);
`else
   modport master (output key_strobe, key_code, clear, view_up, view_down, hex_mode);
   modport slave  (input  key_strobe, key_code, clear, view_up, view_down, hex_mode);
`endif
endinterface

// File: rtl/sevenseg_key_history.sv
// key_history: keycode history with scroll-back window.
//   clk, reset     clock, synchronous active-high reset
//   key_strobe     asynchronous new-data level; one write per rising edge
//   key_code       ASCII code captured on the write cycle
//   clear          empty history (all spaces), view back to 0
//   view_up/down   move the window one character older/newer (saturating)
//   win            DIGITS characters, win[i] = history entry i+view
// Priority: clear > write > view movement.
module key_history
   import sevenseg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int HIST_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_strobe,
   input  logic [7:0]             key_code,
   input  logic                   clear,
   input  logic                   view_up,
   input  logic                   view_down,
   output logic [DIGITS-1:0][7:0] win
);
   localparam int VMAX = HIST_DEPTH - DIGITS;
   localparam int VW   = (VMAX > 0) ? $clog2(VMAX + 1) : 1;
   localparam int HW   = $clog2(HIST_DEPTH);

   // [0],[1] synchroniser flops, [2] previous synchronised level
   logic [2:0]                   sync_q;
   logic                         wr;
   logic [HIST_DEPTH-1:0][7:0]   hist_q;
   logic [VW-1:0]                view_q;

   assign wr = sync_q[1] & ~sync_q[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= {HIST_DEPTH{ASCII_SPACE}};
         view_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], key_strobe};
         if (clear) begin
            hist_q <= {HIST_DEPTH{ASCII_SPACE}};
            view_q <= '0;
         end else if (wr) begin
            hist_q <= {hist_q[HIST_DEPTH-2:0], key_code};
            view_q <= '0;
         end else if (view_up && !view_down && view_q != VW'(VMAX)) begin
            view_q <= view_q + 1'b1;
         end else if (view_down && !view_up && view_q != '0) begin
            view_q <= view_q - 1'b1;
         end
      end
   end

   // i + view never exceeds HIST_DEPTH-1 because view saturates at VMAX
   always_comb begin
      win = '0;
      for (int i = 0; i < DIGITS; i++) win[i] = hist_q[HW'(i) + HW'(view_q)];
   end

endmodule

// File: rtl/sevenseg_scroll_display.sv
// sevenseg_scroll_display: multiplexed 7-segment driver showing the keycode
// history, newest character on the rightmost digit.
//   clk, reset  clock, synchronous active-high reset
//   kb          sevenseg_if.slave control bundle (keys, clear, scroll, hex_mode[, brightness])
//   an          anodes, active-low, one-hot-low or all ones
//   seg         {a,b,c,d,e,f,g,dp}, active-low
// Optional macro SEG_DIM_EN: PWM dimming of the anode on-time from kb.brightness.
// Both outputs are registered: an/seg seen after edge t reflect the scan counters at t,
// and seg is loaded only at phase 0 so a digit never changes glyph mid-slot.
module sevenseg_scroll_display
   import sevenseg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int HIST_DEPTH = 8,
   parameter int GHOST_CYC  = 16
) (
   input  logic              clk,
   input  logic              reset,
   sevenseg_if.slave         kb,
   output logic [DIGITS-1:0] an,
   output logic [7:0]        seg
);
   localparam int SLOT = slot_cycles(CLK_HZ, REFRESH_HZ, DIGITS);
   localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int DW   = $clog2(DIGITS);

   logic [PW-1:0]          phase_q;
   logic [DW-1:0]          idx_q;
   logic [DIGITS-1:0][7:0] win;
   logic [7:0]             seg_nxt;
   logic                   an_en;

   key_history #(.DIGITS(DIGITS), .HIST_DEPTH(HIST_DEPTH)) u_hist (
      .clk        (clk),
      .reset      (reset),
      .key_strobe (kb.key_strobe),
      .key_code   (kb.key_code),
      .clear      (kb.clear),
      .view_up    (kb.view_up),
      .view_down  (kb.view_down),
      .win        (win)
   );

   // glyph for the digit currently being scanned; hex mode shows entry 'view' only
   always_comb begin
      seg_nxt = SEG_BLANK;
      if (kb.hex_mode) begin
         if (idx_q == DW'(0))      seg_nxt = hex_to_seg(win[0][3:0]);
         else if (idx_q == DW'(1)) seg_nxt = hex_to_seg(win[0][7:4]);
      end else begin
         seg_nxt = ascii_to_seg(win[idx_q]);
      end
   end

`ifdef SEG_DIM_EN
   logic [31:0] on_lim;
   always_comb on_lim = 32'(GHOST_CYC)
                      + ((32'(kb.brightness) + 32'd1) * 32'(SLOT - GHOST_CYC)) / 32'd16;
   assign an_en = (32'(phase_q) >= 32'(GHOST_CYC)) && (32'(phase_q) < on_lim);
`else
   assign an_en = 32'(phase_q) >= 32'(GHOST_CYC);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= '0;
         idx_q   <= '0;
         an      <= '1;
         seg     <= SEG_BLANK;
      end else begin
         if (phase_q == PW'(SLOT - 1)) begin
            phase_q <= '0;
            idx_q   <= (idx_q == DW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            phase_q <= phase_q + 1'b1;
         end
         if (phase_q == '0) seg <= seg_nxt;
         an <= an_en ? ~(DIGITS'(1) << idx_q) : '1;
      end
   end

endmodule
